// File: rtl/ddr_burst_ctrl_if.sv
// ddr_burst_ctrl_if: bundles the requester port, the write/read data streams,
// the status pulses and the MCB user port 0 signals of ddr_burst_ctrl.
//   slave  : the controller side (ddr_burst_ctrl)
//   master : the environment side (requester, stream endpoints, MCB)
interface ddr_burst_ctrl_if;
  localparam int unsigned AW  = 30;
  localparam int unsigned LW  = 7;
  localparam int unsigned DW  = 64;
  localparam int unsigned BLW = 6;

  // requester
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          req_ready;
  // write stream
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  // read stream
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  // status
  logic          busy;
  logic          done;
  logic          err;
  // MCB user port 0
  logic           c3_calib_done;
  logic           c3_p0_cmd_en;
  logic [2:0]     c3_p0_cmd_instr;
  logic [BLW-1:0] c3_p0_cmd_bl;
  logic [AW-1:0]  c3_p0_cmd_byte_addr;
  logic           c3_p0_wr_en;
  logic [DW-1:0]  c3_p0_wr_data;
  logic [7:0]     c3_p0_wr_mask;
  logic [LW-1:0]  c3_p0_wr_count;
  logic           c3_p0_rd_en;
  logic [DW-1:0]  c3_p0_rd_data;
  logic           c3_p0_rd_empty;

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    output req_ready,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    output busy, done, err,
    input  c3_calib_done,
    output c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
    output c3_p0_wr_en, c3_p0_wr_data, c3_p0_wr_mask,
    input  c3_p0_wr_count,
    output c3_p0_rd_en,
    input  c3_p0_rd_data, c3_p0_rd_empty
  );

  modport master (
    output req_valid, req_write, req_addr, req_len,
    input  req_ready,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    input  busy, done, err,
    output c3_calib_done,
    input  c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
    input  c3_p0_wr_en, c3_p0_wr_data, c3_p0_wr_mask,
    output c3_p0_wr_count,
    input  c3_p0_rd_en,
    output c3_p0_rd_data, c3_p0_rd_empty
  );
endinterface

// File: rtl/ddr_burst_ctrl.sv
// ddr_burst_ctrl: turns one request (address, word count, direction) into a
// single MCB port-0 burst. Writes stream in_data straight into the MCB write
// FIFO, issue the command and wait for the FIFO to drain; reads issue the
// command and pass the MCB read FIFO (first-word-fall-through) to out_*.
// Ports:
//   clk   : system clock, shared with the MCB user port
//   reset : synchronous, active-high
//   bus   : ddr_burst_ctrl_if.slave (requester, streams, status, MCB port 0)
// Limitation: a reset mid-transfer does not flush the MCB FIFOs.
module ddr_burst_ctrl #(
  parameter int unsigned MAX_BL      = 64,
  parameter int unsigned DRAIN_GUARD = 4
) (
  input  logic            clk,
  input  logic            reset,
  ddr_burst_ctrl_if.slave bus
);
  localparam int unsigned AW  = 30;
  localparam int unsigned LW  = 7;
  localparam int unsigned BLW = 6;
  localparam int unsigned GW  = (DRAIN_GUARD < 1) ? 1 : $clog2(DRAIN_GUARD + 1);

  typedef enum logic [2:0] {
    IDLE, WR_FILL, WR_CMD, WR_DRAIN, RD_CMD, RD_DRAIN
  } state_e;

  state_e         state_q;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BLW-1:0] bl_q, bl_d;
  logic [2:0]     instr_q, instr_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  beat_q;
  logic [GW-1:0]  guard_q;
  logic           done_q;
  logic           err_q;

  logic accept, len_bad, start;
  logic wr_beat, rd_beat, out_valid_c, last_beat, guard_met;

  assign accept  = bus.req_valid && bus.req_ready && !reset;
  assign len_bad = (bus.req_len == '0) || (32'(bus.req_len) > MAX_BL);
  assign start   = accept && !len_bad;

  // Command fields are taken from the _d side so they are already valid in the
  // acceptance cycle, which is the cycle before a read command.
  assign addr_d  = start ? (bus.req_addr & ~AW'(7)) : addr_q;
  assign bl_d    = start ? BLW'(bus.req_len - 1'b1) : bl_q;
  assign instr_d = start ? (bus.req_write ? 3'b000 : 3'b001) : instr_q;
  assign len_d   = start ? bus.req_len : len_q;

  assign wr_beat     = (state_q == WR_FILL) && bus.in_valid;
  assign out_valid_c = (state_q == RD_DRAIN) && !bus.c3_p0_rd_empty;
  assign rd_beat     = out_valid_c && bus.out_ready;
  assign last_beat   = (LW'(beat_q + 1'b1) == len_q);
  assign guard_met   = (guard_q == GW'(DRAIN_GUARD));

  // Requester / stream side
  assign bus.req_ready = (state_q == IDLE) && bus.c3_calib_done;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.in_ready  = (state_q == WR_FILL);
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? bus.c3_p0_rd_data : '0;

  // MCB side
  assign bus.c3_p0_cmd_en        = (state_q == WR_CMD) || (state_q == RD_CMD);
  assign bus.c3_p0_cmd_instr     = instr_d;
  assign bus.c3_p0_cmd_bl        = bl_d;
  assign bus.c3_p0_cmd_byte_addr = addr_d;
  assign bus.c3_p0_wr_en         = wr_beat;
  assign bus.c3_p0_wr_data       = wr_beat ? bus.in_data : '0;
  assign bus.c3_p0_wr_mask       = '0;
  assign bus.c3_p0_rd_en         = rd_beat;

  // Transfer FSM with its counters and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bl_q    <= '0;
      instr_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      guard_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= addr_d;
      bl_q    <= bl_d;
      instr_q <= instr_d;
      len_q   <= len_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            beat_q <= '0;
            if (len_bad) err_q   <= 1'b1;
            else         state_q <= bus.req_write ? WR_FILL : RD_CMD;
          end
        end
        WR_FILL: begin
          if (wr_beat) begin
            beat_q <= LW'(beat_q + 1'b1);
            if (last_beat) state_q <= WR_CMD;
          end
        end
        WR_CMD: begin
          guard_q <= '0;
          state_q <= WR_DRAIN;
        end
        // wr_count lags the command, so it is only trusted once the guard expires
        WR_DRAIN: begin
          if (!guard_met) begin
            guard_q <= GW'(guard_q + 1'b1);
          end else if (bus.c3_p0_wr_count == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        RD_CMD: begin
          beat_q  <= '0;
          state_q <= RD_DRAIN;
        end
        RD_DRAIN: begin
          if (rd_beat) begin
            beat_q <= LW'(beat_q + 1'b1);
            if (last_beat) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ddr_burst_ctrl.md
DDR_BURST_CTRL -- requirements
Module: ddr_burst_ctrl

Interface
REQ-001 SHALL have parameter MAX_BL, default 64: largest transfer in 64-bit words, matching the MCB port FIFO depth.
REQ-002 SHALL have parameter DRAIN_GUARD, default 4: minimum cycles after a write command before c3_p0_wr_count is trusted.
REQ-003 SHALL have port clk  in  1  system clock; single clock domain, shared with the MCB user port.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  transfer request.
REQ-006 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  in  30  byte address.
REQ-008 SHALL have port req_len  in  7  word count.
REQ-009 SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-010 SHALL have port in_data  in  64  write stream data.
REQ-011 SHALL have port in_valid  in  1  write stream valid.
REQ-012 SHALL have port in_ready  out  1  write stream ready.
REQ-013 SHALL have port out_data  out  64  read stream data.
REQ-014 SHALL have port out_valid  out  1  read stream valid.
REQ-015 SHALL have port out_ready  in  1  read stream ready.
REQ-016 SHALL have port busy  out  1  a transfer is in progress.
REQ-017 SHALL have port done  out  1  one-cycle pulse at transfer completion.
REQ-018 SHALL have port err  out  1  one-cycle pulse when a request is rejected.
REQ-019 SHALL have MCB-side ports, directions relative to this block: c3_calib_done in 1; c3_p0_cmd_en out 1; c3_p0_cmd_instr out 3; c3_p0_cmd_bl out 6; c3_p0_cmd_byte_addr out 30; c3_p0_wr_en out 1; c3_p0_wr_data out 64; c3_p0_wr_mask out 8; c3_p0_wr_count in 7; c3_p0_rd_en out 1; c3_p0_rd_data in 64; c3_p0_rd_empty in 1.

Function
REQ-020 SHALL implement states IDLE, WR_FILL, WR_CMD, WR_DRAIN, RD_CMD and RD_DRAIN.
REQ-021 SHALL drive req_ready = (state == IDLE) and c3_calib_done; busy SHALL be high in every state except IDLE.
REQ-022 SHALL accept a request and latch addr, len and write from that handshake cycle; addr[2:0] SHALL be forced to 0.
REQ-023 SHALL reject req_len = 0 or req_len > MAX_BL: err pulses 1 cycle later, state stays IDLE, no MCB activity.
REQ-024 SHALL move an accepted write to WR_FILL, where in_ready = 1 and each in_valid and in_ready beat drives c3_p0_wr_en = 1 with c3_p0_wr_data = in_data in the same cycle.
REQ-025 SHALL hold c3_p0_wr_mask = 0 at all times.
REQ-026 SHALL move to WR_CMD after the len-th beat and drop in_ready in that transition cycle.
REQ-027 SHALL, in WR_CMD, pulse c3_p0_cmd_en for exactly 1 cycle with cmd_instr = 000, cmd_bl = len-1, cmd_byte_addr = latched address, then go to WR_DRAIN.
REQ-028 SHALL hold cmd_instr, cmd_bl and cmd_byte_addr stable from the cycle before cmd_en through the cycle after it.
REQ-029 SHALL, in WR_DRAIN, wait at least DRAIN_GUARD cycles and then until c3_p0_wr_count = 0, then pulse done and return to IDLE.
REQ-030 SHALL move an accepted read to RD_CMD, which pulses cmd_en with cmd_instr = 001, cmd_bl = len-1 and the latched address, then goes to RD_DRAIN.
REQ-031 SHALL, in RD_DRAIN, drive out_valid = ~c3_p0_rd_empty, out_data = c3_p0_rd_data (first-word-fall-through) and c3_p0_rd_en = out_valid and out_ready.
REQ-032 SHALL count each rd_en beat; on the len-th beat it SHALL pulse done next cycle and return to IDLE.
REQ-033 SHALL otherwise hold out_valid, rd_en, wr_en and cmd_en at 0.
REQ-034 SHALL keep at most one MCB command outstanding.
REQ-035 SHALL ignore requests while busy or while c3_calib_done = 0, without raising err.
REQ-036 SHALL allow a new request to be accepted in the cycle done is high.
REQ-037 SHALL add no wrap check: address plus burst crossing the top of memory is the requester's responsibility.

Reset
REQ-038 SHALL, on reset, enter IDLE, clear the counters and drive every output to 0 except req_ready, which follows c3_calib_done.
REQ-039 SHALL let reset mid-transfer abort without issuing further commands; MCB FIFO contents are not flushed, and this is a documented limitation.

Verification
REQ-040 SHALL be verified for a 7-word write of values 20..26 to addr 16: 7 wr_en beats, then one cmd_en with instr 000, bl 6, addr 16; done pulses after wr_count returns to 0.
REQ-041 SHALL be verified for a 7-word read from addr 16 following that write: cmd instr 001, bl 6; out_data returns 20..26 in order, then done.
REQ-042 SHALL be verified for a read with out_ready toggled 1/0 each cycle: no word lost or duplicated, rd_en never high while rd_empty = 1.
REQ-043 SHALL be verified for req_len 0, then 65, then req_addr 19 with len 1: err pulses twice with no MCB activity; the third request issues cmd_byte_addr 16.
REQ-044 SHALL be verified for a request while c3_calib_done = 0: ignored; the same request is accepted once calib_done rises.
REQ-045 SHALL be verified for reset asserted during WR_FILL after 3 beats: next cycle IDLE, busy 0, no cmd_en issued.
